// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding, grant index width and word width for mem_port_arbiter
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    // Wide enough for the largest supported port count (4).
    localparam int PORT_IDX_W = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rtl/mem_port_arbiter_rr_picker.sv - combinational request picker; round-robin, or fixed priority with MEM_ARB_FIXED_PRIO_EN
module rr_picker
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_PORT = 2
) (
    input  logic [N_PORT-1:0]     req,
    input  logic [PORT_IDX_W-1:0] ptr,
    output logic [N_PORT-1:0]     grant,
    output logic [PORT_IDX_W-1:0] grant_idx,
    output logic                  any_req
);

    logic found;

    assign any_req = |req;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N_PORT; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PORT_IDX_W'(i);
            end
        end
    end
`else
    // Scan starts one past the last granted port and wraps around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= N_PORT; k++) begin
            for (int i = 0; i < N_PORT; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % N_PORT) == i)) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = PORT_IDX_W'(i);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory access unit between N_PORT requesters; MEM_ARB_FIXED_PRIO_EN selects fixed priority
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_PORT = 2,
    parameter int W      = `LEN_WORD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PORT-1:0]   req_order,
    input  logic [N_PORT-1:0]   req_io,
    input  logic [N_PORT*W-1:0] req_address,
    input  logic [N_PORT*W-1:0] req_wdata,
    output logic [N_PORT-1:0]   req_accepted,
    output logic [N_PORT-1:0]   req_done,
    output logic [W-1:0]        req_rdata,
    output logic                m_order,
    input  logic                m_accepted,
    input  logic                m_done,
    output logic                m_io,
    output logic [W-1:0]        m_address,
    output logic [W-1:0]        m_wdata,
    input  logic [W-1:0]        m_rdata
);

    arb_state_e            state_q, state_d;
    logic [N_PORT-1:0]     grant_q, grant_d;
    logic [N_PORT-1:0]     req_done_q, req_done_d;
    logic [W-1:0]          req_rdata_q, req_rdata_d;
    logic                  m_order_q, m_order_d;
    logic                  m_io_q, m_io_d;
    logic [W-1:0]          m_address_q, m_address_d;
    logic [W-1:0]          m_wdata_q, m_wdata_d;

    logic [N_PORT-1:0]     pick_req, pick_grant;
    logic [PORT_IDX_W-1:0] pick_idx, ptr_sel;
    logic                  pick_any;
    logic [W-1:0]          sel_address, sel_wdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_pick_idx;
    assign ptr_sel         = '0;
    assign unused_pick_idx = ^pick_idx;
`else
    logic [PORT_IDX_W-1:0] ptr_q, ptr_d;
    assign ptr_sel = ptr_q;
`endif

    // Requests are only visible while idle, so grants can never fire mid-transaction.
    assign pick_req = (state_q == ARB_IDLE) ? req_order : '0;

    rr_picker #(.N_PORT(N_PORT)) u_picker (
        .req       (pick_req),
        .ptr       (ptr_sel),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    always_comb begin
        sel_address = '0;
        sel_wdata   = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (pick_grant[i]) begin
                sel_address = req_address[i*W +: W];
                sel_wdata   = req_wdata[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        req_done_d  = '0;
        req_rdata_d = req_rdata_q;
        m_order_d   = m_order_q;
        m_io_d      = m_io_q;
        m_address_d = m_address_q;
        m_wdata_d   = m_wdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d     = pick_grant;
                    m_io_d      = |(req_io & pick_grant);
                    m_address_d = sel_address;
                    m_wdata_d   = sel_wdata;
                    m_order_d   = 1'b1;
                    state_d     = ARB_ISSUE;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    ptr_d       = pick_idx;
`endif
                end
            end
            ARB_ISSUE: begin
                if (m_accepted) begin
                    m_order_d = 1'b0;
                    if (m_done) begin
                        req_done_d = grant_q;
                        state_d    = ARB_IDLE;
                    end else begin
                        state_d = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                if (m_done) begin
                    req_done_d = grant_q;
                    state_d    = ARB_IDLE;
                end
            end
            default: begin
                m_order_d = 1'b0;
                state_d   = ARB_IDLE;
            end
        endcase
        if (|req_done_d && !m_io_q) begin
            req_rdata_d = m_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            req_done_q  <= '0;
            req_rdata_q <= '0;
            m_order_q   <= 1'b0;
            m_io_q      <= 1'b0;
            m_address_q <= '0;
            m_wdata_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            req_done_q  <= req_done_d;
            req_rdata_q <= req_rdata_d;
            m_order_q   <= m_order_d;
            m_io_q      <= m_io_d;
            m_address_q <= m_address_d;
            m_wdata_q   <= m_wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign req_accepted = pick_grant;
    assign req_done     = req_done_q;
    assign req_rdata    = req_rdata_q;
    assign m_order      = m_order_q;
    assign m_io         = m_io_q;
    assign m_address    = m_address_q;
    assign m_wdata      = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter; expectations follow MEM_ARB_FIXED_PRIO_EN
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_order;
    logic [1:0]  req_io;
    logic [63:0] req_address;
    logic [63:0] req_wdata;
    logic [1:0]  req_accepted;
    logic [1:0]  req_done;
    logic [31:0] req_rdata;
    logic        m_order;
    logic        m_accepted;
    logic        m_done;
    logic        m_io;
    logic [31:0] m_address;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.N_PORT(2), .W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_order    (req_order),
        .req_io       (req_io),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .req_accepted (req_accepted),
        .req_done     (req_done),
        .req_rdata    (req_rdata),
        .m_order      (m_order),
        .m_accepted   (m_accepted),
        .m_done       (m_done),
        .m_io         (m_io),
        .m_address    (m_address),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory unit model: store accepted and done together, load done two cycles after accept.
    logic        hold_accept;
    logic [1:0]  ld_cnt;
    logic [31:0] ld_addr;
    logic [31:0] mem [0:63];

    assign m_accepted = m_order && !hold_accept;
    assign m_done     = (m_accepted && m_io) || (ld_cnt == 2'd1);
    assign m_rdata    = (ld_cnt == 2'd1) ? mem[ld_addr[7:2]] : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt  <= 2'd0;
            ld_addr <= 32'h0;
        end else begin
            if (ld_cnt != 2'd0) ld_cnt <= ld_cnt - 2'd1;
            if (m_accepted && !m_io) begin
                ld_cnt  <= 2'd2;
                ld_addr <= m_address;
            end
            if (m_accepted && m_io) mem[m_address[7:2]] <= m_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [1:0]  exp_grant [4];
    logic [31:0] exp_addr  [4];
    logic [31:0] exp_data  [4];

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_addr  = '{32'h100, 32'h100, 32'h100, 32'h100};
        exp_data  = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
`else
        exp_grant = '{2'b10, 2'b01, 2'b10, 2'b01};
        exp_addr  = '{32'h104, 32'h100, 32'h104, 32'h100};
        exp_data  = '{32'h11111111, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF};
`endif
        rst = 1'b1; req_order = '0; req_io = '0; req_address = '0; req_wdata = '0;
        hold_accept = 1'b0;

        step(); #1;
        chk("rst_done", req_done, 2'b00);
        chk("rst_rdata", req_rdata, 32'h0);
        chk("rst_order", m_order, 1'b0);
        chk("rst_addr", m_address, 32'h0);
        chk("rst_wdata", m_wdata, 32'h0);
        step(); rst = 1'b0;

        // Single store from port 0
        step(); req_order = 2'b01; req_io = 2'b01; req_address[31:0] = 32'h100; req_wdata[31:0] = 32'hDEADBEEF; #1;
        chk("st_acc", req_accepted, 2'b01);
        step(); req_order = 2'b00; #1;
        chk("st_order", m_order, 1'b1);
        chk("st_io", m_io, 1'b1);
        chk("st_addr", m_address, 32'h100);
        chk("st_wdata", m_wdata, 32'hDEADBEEF);
        chk("st_acc_issue", req_accepted, 2'b00);
        step(); #1;
        chk("st_done", req_done, 2'b01);
        chk("st_order_off", m_order, 1'b0);
        step(); #1;
        chk("st_done_pulse", req_done, 2'b00);

        // Single load from port 1
        step(); req_order = 2'b10; req_io = 2'b00; req_address[63:32] = 32'h100; #1;
        chk("ld_acc", req_accepted, 2'b10);
        step(); req_order = 2'b00; #1;
        chk("ld_order", m_order, 1'b1);
        chk("ld_io", m_io, 1'b0);
        step(); #1;
        chk("ld_wait_order", m_order, 1'b0);
        step(); #1;
        chk("ld_done_early", req_done, 2'b00);
        step(); #1;
        chk("ld_done", req_done, 2'b10);
        chk("ld_rdata", req_rdata, 32'hDEADBEEF);

        // Back-to-back stores from port 0
        step(); req_order = 2'b01; req_io = 2'b01; req_address[31:0] = 32'h104; req_wdata[31:0] = 32'h11111111; #1;
        chk("b2b_acc0", req_accepted, 2'b01);
        step(); #1;
        chk("b2b_acc_issue", req_accepted, 2'b00);
        chk("b2b_addr", m_address, 32'h104);
        step(); #1;
        chk("b2b_done0", req_done, 2'b01);
        chk("b2b_acc1", req_accepted, 2'b01);
        step(); req_order = 2'b00; #1;
        chk("b2b_order1", m_order, 1'b1);
        step(); #1;
        chk("b2b_done1", req_done, 2'b01);
        step();

        // Load with m_accepted withheld for 3 cycles
        step(); req_order = 2'b01; req_io = 2'b00; req_address[31:0] = 32'h104; hold_accept = 1'b1; #1;
        chk("stall_acc", req_accepted, 2'b01);
        step(); req_order = 2'b00; #1;
        chk("stall_order1", m_order, 1'b1);
        chk("stall_addr1", m_address, 32'h104);
        step(); #1;
        chk("stall_order2", m_order, 1'b1);
        step(); #1;
        chk("stall_order3", m_order, 1'b1);
        chk("stall_addr3", m_address, 32'h104);
        step(); hold_accept = 1'b0; #1;
        chk("stall_order4", m_order, 1'b1);
        step(); #1;
        chk("stall_wait", m_order, 1'b0);
        step(); #1;
        chk("stall_done_early", req_done, 2'b00);
        step(); #1;
        chk("stall_done", req_done, 2'b01);
        chk("stall_rdata", req_rdata, 32'h11111111);

        // Reset while a load is in WAIT
        step(); req_order = 2'b10; req_io = 2'b00; req_address[63:32] = 32'h100; #1;
        chk("rl_acc", req_accepted, 2'b10);
        step(); req_order = 2'b00;
        step(); #1;
        chk("rl_wait", m_order, 1'b0);
        rst = 1'b1; #1;
        chk("rl_rst_done", req_done, 2'b00);
        chk("rl_rst_rdata", req_rdata, 32'h0);
        chk("rl_rst_addr", m_address, 32'h0);
        step(); rst = 1'b0;
        step(); #1;
        chk("rl_no_done1", req_done, 2'b00);
        step(); #1;
        chk("rl_no_done2", req_done, 2'b00);
        step(); req_order = 2'b01; req_io = 2'b00; req_address[31:0] = 32'h100; #1;
        chk("rl_acc2", req_accepted, 2'b01);
        step(); req_order = 2'b00;
        step();
        step(); #1;
        chk("rl_rdata_hold", req_rdata, 32'h0);
        step(); #1;
        chk("rl_done2", req_done, 2'b01);
        chk("rl_rdata2", req_rdata, 32'hDEADBEEF);

        // Contention from reset: both ports load continuously
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        step(); req_order = 2'b11; req_io = 2'b00;
        req_address[31:0] = 32'h100; req_address[63:32] = 32'h104; #1;
        for (int n = 0; n < 4; n++) begin
            chk("cont_acc", req_accepted, exp_grant[n]);
            if (n > 0) begin
                chk("cont_done", req_done, exp_grant[n-1]);
                chk("cont_rdata", req_rdata, exp_data[n-1]);
            end
            step(); #1;
            chk("cont_addr", m_address, exp_addr[n]);
            step(); step(); step(); #1;
        end
        step(); req_order = 2'b00;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
